// File: rtl/evolve_step_ctrl.sv
// evolve_step_ctrl: speed-button debounce and generation-step handshake control.
//   Debounces btn_inc/btn_dec/btn_step (2-flop sync + stability counter), turns
//   inc/dec press events into one-cycle inc_v/dec_v pulses, picks the generation
//   tick (envolve_v rising edge in run mode, step press in pause mode) and runs a
//   four-phase step_req/step_ack handshake, counting generations and dropped ticks.
// Optional feature macro: STEP_AUTOREPEAT_EN (auto-repeat of held inc/dec buttons).
// Ports:
//   clk, rst (async, active-low)
//   mode                        1 = run (envolve_v ticks), 0 = pause (step button)
//   btn_inc, btn_dec, btn_step  raw asynchronous buttons
//   envolve_v                   speed-controller tick level
//   step_ack                    grid engine acknowledge
//   inc_v, dec_v                one-cycle speed pulses
//   step_req, busy              handshake request / FSM not idle
//   gen_count[15:0]             completed generations (wraps)
//   overrun_cnt[7:0]            ticks dropped while busy (saturates)
module evolve_step_ctrl #(
  parameter logic [19:0] DEBOUNCE      = 20'd1_000_000,
  parameter logic [24:0] REPEAT_DELAY  = 25'd25_000_000,
  parameter logic [24:0] REPEAT_PERIOD = 25'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_step,
  input  logic        envolve_v,
  input  logic        step_ack,
  output logic        inc_v,
  output logic        dec_v,
  output logic        step_req,
  output logic        busy,
  output logic [15:0] gen_count,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned BTN_N = 3;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned GEN_W = 16;
  localparam int unsigned OVR_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Button index: 0 = inc, 1 = dec, 2 = step
  logic [BTN_N-1:0]            btn_raw;
  logic [BTN_N-1:0]            sync1_q, sync2_q;
  logic [BTN_N-1:0]            stable_q, stable_d, stable_prev_q;
  logic [BTN_N-1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [BTN_N-1:0]            press;

  logic             envolve_q;
  logic             tick_q, tick_d;
  logic             inc_v_q, inc_v_d, dec_v_q, dec_v_d;
  logic             rpt_inc, rpt_dec, inc_ev, dec_ev;
  state_t           state_q, state_d;
  logic             step_req_q, step_req_d, busy_q, busy_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [OVR_W-1:0] overrun_cnt_q, overrun_cnt_d;

  assign btn_raw = {btn_step, btn_dec, btn_inc};

  // Stability counter: toggle the stable value after DEBOUNCE differing cycles
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int unsigned i = 0; i < BTN_N; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DEBOUNCE) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RPT_W = 25;

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             rpt_fire;
  logic             rpt_run;

  // Repeat only while exactly one speed button is held
  assign rpt_run = stable_q[0] ^ stable_q[1];

  // Counts from the press event; first fire after REPEAT_DELAY, then every REPEAT_PERIOD
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_fire    = 1'b0;
    if (!rpt_run || press[0] || press[1]) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (rpt_cnt_q == (rpt_first_q ? REPEAT_DELAY : REPEAT_PERIOD) - RPT_W'(1)) begin
      rpt_fire    = 1'b1;
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
    end else begin
      rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  assign rpt_inc = rpt_fire & stable_q[0];
  assign rpt_dec = rpt_fire & stable_q[1];
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rpt_inc = 1'b0;
  assign rpt_dec = 1'b0;
`endif

  // Simultaneous inc and dec events cancel each other
  assign inc_ev  = press[0] | rpt_inc;
  assign dec_ev  = press[1] | rpt_dec;
  assign inc_v_d = inc_ev & ~dec_ev;
  assign dec_v_d = dec_ev & ~inc_ev;

  // Tick from the selected source, registered before the FSM sees it
  assign tick_d = mode ? (envolve_v & ~envolve_q) : press[2];

  // Handshake FSM plus generation / overrun counters
  always_comb begin
    state_d       = state_q;
    gen_count_d   = gen_count_q;
    overrun_cnt_d = overrun_cnt_q;
    unique case (state_q)
      IDLE: if (tick_q) state_d = REQ;
      REQ: begin
        if (step_ack) begin
          state_d     = DONE;
          gen_count_d = gen_count_q + GEN_W'(1);
        end
      end
      DONE:    if (!step_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tick_q && (state_q != IDLE) && (overrun_cnt_q != '1)) begin
      overrun_cnt_d = overrun_cnt_q + OVR_W'(1);
    end
  end

  assign step_req_d = (state_d == REQ);
  assign busy_d     = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '0;
      envolve_q     <= 1'b0;
      tick_q        <= 1'b0;
      inc_v_q       <= 1'b0;
      dec_v_q       <= 1'b0;
      state_q       <= IDLE;
      step_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      gen_count_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
      envolve_q     <= envolve_v;
      tick_q        <= tick_d;
      inc_v_q       <= inc_v_d;
      dec_v_q       <= dec_v_d;
      state_q       <= state_d;
      step_req_q    <= step_req_d;
      busy_q        <= busy_d;
      gen_count_q   <= gen_count_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign inc_v       = inc_v_q;
  assign dec_v       = dec_v_q;
  assign step_req    = step_req_q;
  assign busy        = busy_q;
  assign gen_count   = gen_count_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_evolve_step_ctrl.sv
// Bench for evolve_step_ctrl: directed button/handshake scenarios, then a
// randomized run-mode phase checked against a timeline model of the handshake.
module tb_evolve_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk, rst, mode, btn_inc, btn_dec, btn_step, envolve_v, step_ack;
  logic        inc_v, dec_v, step_req, busy;
  logic [15:0] gen_count;
  logic [7:0]  overrun_cnt;

  int vectors;
  int miscompares;
  int exp_gen;
  int exp_ovr;

  evolve_step_ctrl #(
    .DEBOUNCE     (20'd4),
    .REPEAT_DELAY (25'd20),
    .REPEAT_PERIOD(25'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .btn_step   (btn_step),
    .envolve_v  (envolve_v),
    .step_ack   (step_ack),
    .inc_v      (inc_v),
    .dec_v      (dec_v),
    .step_req   (step_req),
    .busy       (busy),
    .gen_count  (gen_count),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Run-mode handshake: envolve_v rise, ack for two samples, then release
  task automatic do_handshake();
    int lat;
    lat = -1;
    envolve_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lat < 0 && step_req === 1'b1) lat = i;
    end
    check("hs_req_latency", 32'(lat), 32'd1);
    step_ack = 1'b1;
    @(negedge clk);
    exp_gen = (exp_gen + 1) % 65536;
    check("hs_gen", 32'(gen_count), 32'(exp_gen));
    @(negedge clk);
    step_ack  = 1'b0;
    envolve_v = 1'b0;
    nxt(2);
    check("hs_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_gen = 0; exp_ovr = 0;
    rst = 1'b0; mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_step = 1'b0;
    envolve_v = 1'b0; step_ack = 1'b0;
    #12;
    check("rst_inc_v", 32'(inc_v), 32'd0);
    check("rst_dec_v", 32'(dec_v), 32'd0);
    check("rst_step_req", 32'(step_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gen", 32'(gen_count), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    nxt(3);

    // inc held 40 cycles: pulse after edge DB+3 (plus repeats with the macro)
    btn_inc = 1'b1;
    for (int j = 0; j < 40; j++) begin
      logic e;
      @(negedge clk);
      e = (j == DB + 3);
`ifdef STEP_AUTOREPEAT_EN
      if (j >= DB + 3 + RD && ((j - DB - 3 - RD) % RP) == 0) e = 1'b1;
`endif
      check("inc_hold_inc_v", 32'(inc_v), 32'(e));
      check("inc_hold_dec_v", 32'(dec_v), 32'd0);
    end
    btn_inc = 1'b0;
    nxt(15);

    // Short dec glitch
    btn_dec = 1'b1;
    nxt(3);
    btn_dec = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      check("glitch_dec_v", 32'(dec_v), 32'd0);
    end

    // Both buttons together: suppressed
    btn_inc = 1'b1; btn_dec = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("both_inc_v", 32'(inc_v), 32'd0);
      check("both_dec_v", 32'(dec_v), 32'd0);
    end
    btn_inc = 1'b0; btn_dec = 1'b0;
    nxt(15);

    // step_ack in IDLE ignored
    mode = 1'b1; step_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("idle_ack_busy", 32'(busy), 32'd0);
      check("idle_ack_gen", 32'(gen_count), 32'(exp_gen));
    end
    step_ack = 1'b0;
    @(negedge clk);

    // Single run-mode handshake with exact timing
    envolve_v = 1'b1;
    @(negedge clk); check("tick_req_k", 32'(step_req), 32'd0);
    @(negedge clk); check("tick_req_k1", 32'(step_req), 32'd1);
    check("tick_busy_k1", 32'(busy), 32'd1);
    @(negedge clk); check("tick_req_k2", 32'(step_req), 32'd1);
    step_ack = 1'b1;
    @(negedge clk); exp_gen++;
    check("ack_req_drop", 32'(step_req), 32'd0);
    check("ack_gen", 32'(gen_count), 32'(exp_gen));
    check("ack_busy", 32'(busy), 32'd1);
    @(negedge clk); check("done_busy", 32'(busy), 32'd1);
    step_ack = 1'b0;
    @(negedge clk); check("idle_busy", 32'(busy), 32'd0);
    envolve_v = 1'b0;
    nxt(2);

    // Three ticks while ack withheld: one generation, two overruns
    for (int i = 0; i < 30; i++) begin
      envolve_v = (i < 3) || (i >= 6 && i < 9) || (i >= 12);
      @(negedge clk);
    end
    check("ovr_hold_req", 32'(step_req), 32'd1);
    step_ack = 1'b1; nxt(2); step_ack = 1'b0; envolve_v = 1'b0; nxt(2);
    exp_gen++; exp_ovr += 2;
    check("ovr3_gen", 32'(gen_count), 32'(exp_gen));
    check("ovr3_ovr", 32'(overrun_cnt), 32'(exp_ovr));

    // Pause mode: envolve_v ignored, step button starts a handshake
    mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      envolve_v = i[1];
      @(negedge clk);
      check("pause_no_req", 32'(step_req), 32'd0);
    end
    envolve_v = 1'b0;
    nxt(2);
    begin : step_press
      int lat;
      lat = -1;
      btn_step = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (lat < 0 && step_req === 1'b1) lat = i;
      end
      check("step_req_latency", 32'(lat), 32'(DB + 4));
    end
    mode = 1'b1;  // mode change mid-handshake must not abort it
    nxt(2);
    check("mode_chg_req", 32'(step_req), 32'd1);
    step_ack = 1'b1; nxt(2); step_ack = 1'b0; btn_step = 1'b0; nxt(2);
    exp_gen++;
    check("step_gen", 32'(gen_count), 32'(exp_gen));
    check("step_busy", 32'(busy), 32'd0);
    nxt(12);

    // Randomized run/pause phase against a timeline model
    begin : rand_phase
      bit act, pend, m, env_p, env_n, ack_n, tick, busy_now, exp_req, exp_busy;
      int a, as_e, b;
      act = 0; pend = 0; m = 1; env_p = 0; exp_req = 0; exp_busy = 0;
      a = 0; as_e = 0; b = 0;
      for (int t = 0; t < 3012; t++) begin
        @(negedge clk);
        check("rnd_req", 32'(step_req), 32'(exp_req));
        check("rnd_busy", 32'(busy), 32'(exp_busy));
        check("rnd_gen", 32'(gen_count), 32'(exp_gen));
        check("rnd_ovr", 32'(overrun_cnt), 32'(exp_ovr));
        if (t < 3000) begin
          if ($urandom_range(63) == 0) m = ~m;
          env_n = ($urandom_range(3) == 0) ? ~env_p : env_p;
        end else begin
          env_n = env_p;
        end
        ack_n = act && (t >= as_e) && (t < b);
        mode = m; envolve_v = env_n; step_ack = ack_n;
        if (pend) exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
        pend = 0;
        if (act && t == as_e) exp_gen = (exp_gen + 1) % 65536;
        busy_now = act && (t >= a + 1) && (t < b);
        tick = m && env_n && !env_p;
        env_p = env_n;
        if (tick) begin
          if (busy_now) pend = 1;
          else begin
            act = 1; a = t;
            as_e = t + 1 + int'($urandom_range(4, 1));
            b = as_e + int'($urandom_range(3, 1));
          end
        end
        exp_req  = act && (t >= a + 1) && (t < as_e);
        exp_busy = act && (t >= a + 1) && (t < b);
      end
      @(negedge clk);
      check("rnd_end_busy", 32'(busy), 32'(exp_busy));
      mode = 1'b1; envolve_v = 1'b0; step_ack = 1'b0;
      nxt(2);
    end

    // Overrun saturation: 300 dropped ticks
    for (int i = 0; i < 602; i++) begin
      envolve_v = (i % 2 == 0);
      @(negedge clk);
    end
    step_ack = 1'b1; nxt(2); step_ack = 1'b0; nxt(2);
    exp_gen = (exp_gen + 1) % 65536;
    exp_ovr = (exp_ovr + 300 > 255) ? 255 : exp_ovr + 300;
    check("sat_ovr", 32'(overrun_cnt), 32'(exp_ovr));
    check("sat_gen", 32'(gen_count), 32'(exp_gen));

    // Generation counter wrap from 16'hFFFF
    force dut.gen_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.gen_count_q;
    @(negedge clk);
    exp_gen = 65535;
    check("preload_gen", 32'(gen_count), 32'(exp_gen));
    do_handshake();
    check("wrap_gen", 32'(gen_count), 32'd0);
    do_handshake();

    // Reset while in REQ
    envolve_v = 1'b1;
    nxt(2);
    check("pre_rst_req", 32'(step_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_req_req", 32'(step_req), 32'd0);
    check("rst_req_busy", 32'(busy), 32'd0);
    check("rst_req_gen", 32'(gen_count), 32'd0);
    check("rst_req_ovr", 32'(overrun_cnt), 32'd0);
    envolve_v = 1'b0;
    nxt(2);
    rst = 1'b1;
    nxt(3);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
